// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32 load/store funct3 codes, trap causes and access-size helper.
package lsu_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [3:0] CAUSE_NONE   = 4'd0;
    localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
    localparam logic [3:0] CAUSE_LD_FLT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
    localparam logic [3:0] CAUSE_ST_FLT = 4'd7;
    // Access size as AXI size code: 0 byte, 1 half, 2 word (unknown funct3 counts as word).
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        return (funct3 == F3_H || funct3 == F3_HU) ? 2'd1 :
               (funct3 == F3_B || funct3 == F3_BU) ? 2'd0 : 2'd2;
    endfunction
endpackage

// File: rtl/lsu_axi_ctrl_lane_align.sv
// lsu_lane_align: places store data/strobe on the byte lane and extracts/extends load data from it.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic                        in_region,
    input  logic [2:0]                  funct3,
    input  logic [31:0]                 st_data,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [DATA_W-1:0]           wdata,
    output logic [31:0]                 ld_data
);
    localparam int LB = $clog2(DATA_W/8);
    localparam int SW = DATA_W/8;
    logic [1:0]    sz;
    logic [3:0]    mask;
    logic [LB-1:0] ld_lane;
    logic [31:0]   sh;
    assign sz    = size_of(funct3);
    assign mask  = sz == 2'd0 ? 4'h1 : sz == 2'd1 ? 4'h3 : 4'hf;
    assign wstrb = SW'(mask) << lane;
    assign wdata = DATA_W'(st_data) << {lane, 3'b000};
    // Loads outside the full-width region come back on lane 0 from narrow slaves.
    assign ld_lane = in_region ? lane : '0;
    assign sh      = 32'(rdata >> {ld_lane, 3'b000});
    assign ld_data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                     funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                     funct3 == F3_W  ? sh :
                     funct3 == F3_BU ? {24'h0, sh[7:0]} :
                     funct3 == F3_HU ? {16'h0, sh[15:0]} : 32'h0;
endmodule

// File: rtl/lsu_axi_ctrl.sv
// lsu_axi_ctrl: single-outstanding load/store unit driving an AXI-lite master port.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses without bus traffic.
module lsu_axi_ctrl
    import lsu_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] WORD_BASE = 32'h0f000000,
    parameter logic [ADDR_W-1:0] WORD_END  = 32'h10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic [3:0]          resp_cause,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    localparam int LB = $clog2(DATA_W/8);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RD   = ST_RD;
    localparam logic [1:0] WR   = ST_WR;
    localparam logic [1:0] RESP = ST_RESP;
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic              in_region, mis, aw_done, w_done;
    logic [ADDR_W-1:0] bus_addr;
    logic [2:0]        bus_size;
    logic [31:0]       ld_data;
    assign in_region  = addr_q >= WORD_BASE && addr_q < WORD_END;
    assign bus_addr   = in_region ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : addr_q;
    assign bus_size   = in_region ? 3'(LB) : {1'b0, size_of(f3_q)};
    assign araddr     = bus_addr;
    assign awaddr     = bus_addr;
    assign arsize     = bus_size;
    assign awsize     = bus_size;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign aw_done    = !awvalid || awready;
    assign w_done     = !wvalid || wready;
`ifdef LSU_MISALIGN_TRAP_EN
    logic [1:0] req_sz;
    assign req_sz = size_of(req_funct3);
    assign mis = (req_sz == 2'd1 && req_addr[0]) || (req_sz == 2'd2 && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane      (addr_q[LB-1:0]),
        .in_region (in_region),
        .funct3    (f3_q),
        .st_data   (wdata_q),
        .rdata     (rdata),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .ld_data   (ld_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            resp_cause <= CAUSE_NONE;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            f3_q       <= 3'b000;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    f3_q    <= req_funct3;
                    if (mis) begin
                        state      <= RESP;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b1;
                        resp_cause <= req_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                    end else if (req_we) begin
                        state   <= WR;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else begin
                        state   <= RD;
                        arvalid <= 1'b1;
                    end
                end
                RD: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                    if (rready && rvalid) begin
                        rready     <= 1'b0;
                        state      <= RESP;
                        resp_rdata <= rresp != 2'b00 ? 32'h0 : ld_data;
                        resp_err   <= rresp != 2'b00;
                        resp_cause <= rresp != 2'b00 ? CAUSE_LD_FLT : CAUSE_NONE;
                    end
                end
                WR: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    // B is only accepted once both AW and W have handshaken.
                    if (!bready && aw_done && w_done) bready <= 1'b1;
                    if (bready && bvalid) begin
                        bready     <= 1'b0;
                        state      <= RESP;
                        resp_rdata <= 32'h0;
                        resp_err   <= bresp != 2'b00;
                        resp_cause <= bresp != 2'b00 ? CAUSE_ST_FLT : CAUSE_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// tb_lsu_axi_ctrl: directed checks of a 32-bit and a 64-bit lsu_axi_ctrl sharing one scripted AXI slave.
module tb_lsu_axi_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [2:0] req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [63:0] rdata = 64'h0;
    logic [1:0] rresp = 2'b00, bresp = 2'b00;

    logic req_ready_a, resp_valid_a, resp_err_a, arvalid_a, rready_a, awvalid_a, wvalid_a, bready_a;
    logic [31:0] resp_rdata_a, araddr_a, awaddr_a, wdata_a;
    logic [3:0] resp_cause_a, wstrb_a;
    logic [2:0] arsize_a, awsize_a;
    logic req_ready_b, resp_valid_b, resp_err_b, arvalid_b, rready_b, awvalid_b, wvalid_b, bready_b;
    logic [31:0] resp_rdata_b, araddr_b, awaddr_b;
    logic [63:0] wdata_b;
    logic [7:0] wstrb_b;
    logic [3:0] resp_cause_b;
    logic [2:0] arsize_b, awsize_b;

    int checks = 0;
    int errors = 0;
    int lat;
    logic ar_seen, pulse2;
    logic [31:0] ar_a32, ar_a64, aw_a32, aw_a64, wd32, r32, r64;
    logic [2:0] ar_s32, ar_s64, aw_s32, aw_s64;
    logic [3:0] ws32, c32, c64;
    logic [63:0] wd64;
    logic [7:0] ws64;
    logic e32, e64;

    always #5 clk = ~clk;

    lsu_axi_ctrl #(.DATA_W(32)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .resp_cause(resp_cause_a),
        .araddr(araddr_a), .arsize(arsize_a), .arvalid(arvalid_a), .arready(arready),
        .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid), .rready(rready_a),
        .awaddr(awaddr_a), .awsize(awsize_a), .awvalid(awvalid_a), .awready(awready),
        .wdata(wdata_a), .wstrb(wstrb_a), .wvalid(wvalid_a), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready_a)
    );

    lsu_axi_ctrl #(.DATA_W(64)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .resp_cause(resp_cause_b),
        .araddr(araddr_b), .arsize(arsize_b), .arvalid(arvalid_b), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_b),
        .awaddr(awaddr_b), .awsize(awsize_b), .awvalid(awvalid_b), .awready(awready),
        .wdata(wdata_b), .wstrb(wstrb_b), .wvalid(wvalid_b), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready_b)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic grab_resp();
        r32 = resp_rdata_a; e32 = resp_err_a; c32 = resp_cause_a;
        r64 = resp_rdata_b; e64 = resp_err_b; c64 = resp_cause_b;
        cyc();
        pulse2 = resp_valid_a | resp_valid_b;
    endtask

    // Zero-wait read slave; lat = clock edges from request acceptance to the visible response.
    task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] rd, input logic [1:0] rr);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a; req_wdata = 32'h0;
        rdata = rd; rresp = rr; ar_seen = 1'b0; lat = -1;
        cyc();
        req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (resp_valid_a) begin
                lat = i;
                break;
            end
            if (arvalid_a) begin
                ar_seen = 1'b1; ar_a32 = araddr_a; ar_s32 = arsize_a; ar_a64 = araddr_b; ar_s64 = arsize_b;
            end
            arready = arvalid_a;
            rvalid = rready_a;
            cyc();
        end
        arready = 1'b0; rvalid = 1'b0;
        grab_resp();
    endtask

    // Write slave with independent AW/W ready delays; B is offered eagerly throughout.
    task automatic run_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd, input logic [1:0] br,
                             input int ad, input int wdl);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
        bresp = br; bvalid = 1'b1; lat = -1;
        cyc();
        req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (resp_valid_a) begin
                lat = i;
                break;
            end
            if (i == 1) begin
                aw_a32 = awaddr_a; aw_s32 = awsize_a; aw_a64 = awaddr_b; aw_s64 = awsize_b;
                wd32 = wdata_a; ws32 = wstrb_a; wd64 = wdata_b; ws64 = wstrb_b;
            end
            awready = awvalid_a && (i - 1 >= ad);
            wready = wvalid_a && (i - 1 >= wdl);
            cyc();
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        grab_resp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        checks++;
        if ({req_ready_a, arvalid_a, rready_a, awvalid_a, wvalid_a, bready_a, resp_valid_a, resp_err_a} !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_ctrl32 got %b exp 10000000",
                {req_ready_a, arvalid_a, rready_a, awvalid_a, wvalid_a, bready_a, resp_valid_a, resp_err_a});
        end
        checks++;
        if ({resp_rdata_a, resp_cause_a, resp_rdata_b, resp_cause_b, req_ready_b, resp_valid_b} !== 74'b10) begin
            errors++; $display("FAIL reset_resp got %h/%h/%h/%h rdy64 %b exp zeros, rdy64 1",
                resp_rdata_a, resp_cause_a, resp_rdata_b, resp_cause_b, req_ready_b);
        end
    endtask

    task automatic test_load_wide();
        run_load(32'h0f000004, 3'b010, 64'h11223344_55667788, 2'b00);
        checks++;
        if ({ar_a64, ar_s64} !== {32'h0f000000, 3'd3}) begin
            errors++; $display("FAIL lw64_ar got %h/%0d exp 0f000000/3", ar_a64, ar_s64);
        end
        checks++;
        if (r64 !== 32'h11223344) begin errors++; $display("FAIL lw64_data got %h exp 11223344", r64); end
        checks++;
        if ({ar_a32, ar_s32, r32} !== {32'h0f000004, 3'd2, 32'h55667788}) begin
            errors++; $display("FAIL lw32 got %h/%0d/%h exp 0f000004/2/55667788", ar_a32, ar_s32, r32);
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
        checks++;
        if (pulse2 !== 1'b0) begin errors++; $display("FAIL lw_single_pulse got %b exp 0", pulse2); end
    endtask

    task automatic test_load_extend();
        run_load(32'h0f000003, 3'b000, 64'h00000000_80123456, 2'b00);
        checks++;
        if ({r32, r64, e32} !== {32'hffffff80, 32'hffffff80, 1'b0}) begin
            errors++; $display("FAIL lb got %h/%h err %b exp ffffff80/ffffff80/0", r32, r64, e32);
        end
        checks++;
        if ({ar_a32, ar_s32} !== {32'h0f000000, 3'd2}) begin
            errors++; $display("FAIL lb_ar got %h/%0d exp 0f000000/2", ar_a32, ar_s32);
        end
        run_load(32'h0f000003, 3'b100, 64'h00000000_80123456, 2'b00);
        checks++;
        if ({r32, r64} !== {32'h00000080, 32'h00000080}) begin
            errors++; $display("FAIL lbu got %h/%h exp 00000080", r32, r64);
        end
        run_load(32'h20000002, 3'b001, 64'h00000000_55aa8001, 2'b00);
        checks++;
        if ({ar_a32, ar_s32, r32} !== {32'h20000002, 3'd1, 32'hffff8001}) begin
            errors++; $display("FAIL lh_out got %h/%0d/%h exp 20000002/1/ffff8001", ar_a32, ar_s32, r32);
        end
        run_load(32'h20000002, 3'b101, 64'h00000000_55aa8001, 2'b00);
        checks++;
        if (r32 !== 32'h00008001) begin errors++; $display("FAIL lhu_out got %h exp 00008001", r32); end
        run_load(32'h20000000, 3'b011, 64'h00000000_deadbeef, 2'b00);
        checks++;
        if ({r32, e32, c32} !== {32'h0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL f3_011 got %h/%b/%0d exp 0/0/0", r32, e32, c32);
        end
    endtask

    task automatic test_load_error();
        run_load(32'h20000000, 3'b010, 64'h00000000_deadbeef, 2'b11);
        checks++;
        if ({r32, e32, c32, e64, c64} !== {32'h0, 1'b1, 4'd5, 1'b1, 4'd5}) begin
            errors++; $display("FAIL lw_fault got %h/%b/%0d 64:%b/%0d exp 0/1/5", r32, e32, c32, e64, c64);
        end
    endtask

    task automatic test_store();
        run_store(32'h10000001, 3'b000, 32'h000000ab, 2'b00, 0, 0);
        checks++;
        if ({aw_a32, aw_s32, ws32, wd32} !== {32'h10000001, 3'd0, 4'b0010, 32'h0000ab00}) begin
            errors++; $display("FAIL sb_out got %h/%0d/%b/%h exp 10000001/0/0010/0000ab00", aw_a32, aw_s32, ws32, wd32);
        end
        checks++;
        if ({ws64, wd64} !== {8'h02, 64'h0000ab00}) begin
            errors++; $display("FAIL sb_out64 got %h/%h exp 02/000000000000ab00", ws64, wd64);
        end
        checks++;
        if ({lat, e32, c32, r32} !== {32'd3, 1'b0, 4'd0, 32'h0}) begin
            errors++; $display("FAIL sb_resp got lat %0d %b/%0d/%h exp 3 0/0/0", lat, e32, c32, r32);
        end
        run_store(32'h0f000006, 3'b001, 32'h0000beef, 2'b00, 0, 0);
        checks++;
        if ({aw_a32, aw_s32, ws32, wd32} !== {32'h0f000004, 3'd2, 4'b1100, 32'hbeef0000}) begin
            errors++; $display("FAIL sh_in32 got %h/%0d/%b/%h exp 0f000004/2/1100/beef0000", aw_a32, aw_s32, ws32, wd32);
        end
        checks++;
        if ({aw_a64, aw_s64, ws64, wd64} !== {32'h0f000000, 3'd3, 8'hc0, 64'hbeef0000_00000000}) begin
            errors++; $display("FAIL sh_in64 got %h/%0d/%h/%h exp 0f000000/3/c0/beef000000000000", aw_a64, aw_s64, ws64, wd64);
        end
    endtask

    task automatic test_store_order();
        run_store(32'h20000000, 3'b010, 32'h12345678, 2'b10, 0, 3);
        checks++;
        if ({lat, e32, c32, pulse2} !== {32'd6, 1'b1, 4'd7, 1'b0}) begin
            errors++; $display("FAIL sw_w_late got lat %0d err %b cause %0d extra %b exp 6 1 7 0", lat, e32, c32, pulse2);
        end
        run_store(32'h20000000, 3'b010, 32'h12345678, 2'b00, 2, 0);
        checks++;
        if ({lat, e32, c32} !== {32'd5, 1'b0, 4'd0}) begin
            errors++; $display("FAIL sw_aw_late got lat %0d err %b cause %0d exp 5 0 0", lat, e32, c32);
        end
    endtask

    task automatic test_misalign();
        run_load(32'h0f000001, 3'b001, 64'h00000000_00ff8000, 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if ({ar_seen, e32, c32, r32} !== {1'b0, 1'b1, 4'd4, 32'h0}) begin
            errors++; $display("FAIL lh_mis got ar %b %b/%0d/%h exp 0 1/4/0", ar_seen, e32, c32, r32);
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lh_mis_latency got %0d exp 1", lat); end
        run_store(32'h20000002, 3'b010, 32'h1, 2'b00, 0, 0);
        checks++;
        if ({e32, c32, lat} !== {1'b1, 4'd6, 32'd1}) begin
            errors++; $display("FAIL sw_mis got %b/%0d lat %0d exp 1/6/1", e32, c32, lat);
        end
`else
        checks++;
        if ({ar_seen, ar_a32, ar_s32} !== {1'b1, 32'h0f000000, 3'd2}) begin
            errors++; $display("FAIL lh_mis_ar got %b %h/%0d exp 1 0f000000/2", ar_seen, ar_a32, ar_s32);
        end
        checks++;
        if ({e32, r32} !== {1'b0, 32'hffffff80}) begin
            errors++; $display("FAIL lh_mis_data got %b/%h exp 0/ffffff80", e32, r32);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0f000000;
        cyc();
        req_valid = 1'b0;
        checks++;
        if (arvalid_a !== 1'b1) begin errors++; $display("FAIL rstmid_pre got arvalid %b exp 1", arvalid_a); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({arvalid_a, req_ready_a, resp_valid_a} !== 3'b010) begin
            errors++; $display("FAIL rstmid_post got ar/rdy/resp %b exp 010", {arvalid_a, req_ready_a, resp_valid_a});
        end
        for (int i = 0; i < 4; i++) begin
            seen = seen | resp_valid_a | arvalid_a;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got %b exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        run_load(32'h20000000, 3'b010, 64'h00000000_cafef00d, 2'b00);
        run_load(32'h20000004, 3'b010, 64'h00000000_0badc0de, 2'b00);
        checks++;
        if ({r32, lat} !== {32'h0badc0de, 32'd3}) begin
            errors++; $display("FAIL b2b got %h lat %0d exp 0badc0de 3", r32, lat);
        end
        rdata = 64'h0;
        cyc(); cyc();
        checks++;
        if ({resp_rdata_a, resp_valid_a} !== {32'h0badc0de, 1'b0}) begin
            errors++; $display("FAIL resp_hold got %h v %b exp 0badc0de 0", resp_rdata_a, resp_valid_a);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_wide();
        test_load_extend();
        test_load_error();
        test_store();
        test_store_order();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
